// File: rtl/gptp_tx_scheduler.sv
// Round-robin arbiter sharing one gPTP send/timestamp path; one frame in flight, 1-cycle grant latency.
// Holds the frame until gptp_ts_ready; waits for the write-back or TS_TIMEOUT, then enforces MIN_GAP idle cycles.
module gptp_tx_scheduler #(
    parameter int          NUM_REQ    = 4,
    parameter int          FRAME_W    = 352,
    parameter int          TS_W       = 80,
    parameter logic [15:0] TS_TIMEOUT = 16'd1000,
    parameter logic [7:0]  MIN_GAP    = 8'd4
) (
    input  logic                       clk_sd,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_en,
    input  logic [NUM_REQ-1:0]         req_vaild,
    input  logic [NUM_REQ*FRAME_W-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       gptp_ts_vaild,
    input  logic                       gptp_ts_ready,
    output logic [FRAME_W-1:0]         gptp_ts_data,
    input  logic                       gptp_ts_rv_vaild,
    input  logic [TS_W-1:0]            gptp_ts_rv_data,
    output logic                       ts_out_vaild,
    output logic [TS_W-1:0]            ts_out_data,
    output logic [2:0]                 ts_out_id,
    output logic                       ts_out_err,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_TS, GAP} state_t;

    state_t               state_q;
    logic [2:0]           rr_ptr_q;
    logic [15:0]          tmo_cnt_q;
    logic [7:0]           gap_cnt_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic                 vld_q;
    logic [FRAME_W-1:0]   data_q;
    logic                 tsv_q;
    logic [TS_W-1:0]      tsd_q;
    logic [2:0]           id_q;
    logic                 err_q;

    logic [NUM_REQ-1:0]   cand;
    logic [NUM_REQ-1:0]   win_oh;
    logic [2:0]           win_idx;
    logic [2:0]           hi_idx;
    logic [2:0]           lo_idx;
    logic                 hi_found;
    logic [FRAME_W-1:0]   win_data;
    logic [2:0]           rr_ptr_d;

    // Winner: lowest candidate at or above rr_ptr, else lowest candidate overall (wrap).
    always_comb begin
        cand     = req_vaild & req_en;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                lo_idx = 3'(i);
                if (3'(i) >= rr_ptr_q) begin
                    hi_idx   = 3'(i);
                    hi_found = 1'b1;
                end
            end
        end
        win_idx  = hi_found ? hi_idx : lo_idx;
        win_oh   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == win_idx) begin
                win_oh[i] = 1'b1;
                win_data  = req_data[i*FRAME_W +: FRAME_W];
            end
        end
        rr_ptr_d = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
    end

    always_ff @(posedge clk_sd) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            tmo_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            req_ready_q <= '0;
            vld_q       <= 1'b0;
            data_q      <= '0;
            tsv_q       <= 1'b0;
            tsd_q       <= '0;
            id_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            req_ready_q <= '0;
            tsv_q       <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|cand) begin
                        req_ready_q <= win_oh;
                        data_q      <= win_data;
                        id_q        <= win_idx;
                        rr_ptr_q    <= rr_ptr_d;
                        vld_q       <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (gptp_ts_ready) begin
                        vld_q     <= 1'b0;
                        tmo_cnt_q <= '0;
                        state_q   <= WAIT_TS;
                    end
                end
                WAIT_TS: begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    // A write-back arriving on the timeout cycle still counts as delivered.
                    if (gptp_ts_rv_vaild) begin
                        tsd_q     <= gptp_ts_rv_data;
                        tsv_q     <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end else if (tmo_cnt_q == TS_TIMEOUT - 16'd1) begin
                        err_q     <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (({1'b0, gap_cnt_q} + 9'd1) >= {1'b0, MIN_GAP}) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign gptp_ts_vaild = vld_q;
    assign gptp_ts_data  = data_q;
    assign ts_out_vaild  = tsv_q;
    assign ts_out_data   = tsd_q;
    assign ts_out_id     = id_q;
    assign ts_out_err    = err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_gptp_tx_scheduler.sv
// Bench for gptp_tx_scheduler: directed and random phases against an interval-level schedule model.
module tb_gptp_tx_scheduler;
    localparam int N    = 4;
    localparam int FW   = 352;
    localparam int TW   = 80;
    localparam int T    = 20;
    localparam int MG   = 4;
    localparam int MAXL = 320;

    logic              clk_sd = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_en = '0;
    logic [N-1:0]      req_vaild = '0;
    logic [N*FW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              gptp_ts_vaild;
    logic              gptp_ts_ready = 1'b0;
    logic [FW-1:0]     gptp_ts_data;
    logic              gptp_ts_rv_vaild = 1'b0;
    logic [TW-1:0]     gptp_ts_rv_data = '0;
    logic              ts_out_vaild;
    logic [TW-1:0]     ts_out_data;
    logic [2:0]        ts_out_id;
    logic              ts_out_err;
    logic              busy;

    gptp_tx_scheduler #(
        .NUM_REQ(N), .FRAME_W(FW), .TS_W(TW), .TS_TIMEOUT(16'd20), .MIN_GAP(8'd4)
    ) dut (
        .clk_sd(clk_sd), .reset(reset), .req_en(req_en), .req_vaild(req_vaild),
        .req_data(req_data), .req_ready(req_ready), .gptp_ts_vaild(gptp_ts_vaild),
        .gptp_ts_ready(gptp_ts_ready), .gptp_ts_data(gptp_ts_data),
        .gptp_ts_rv_vaild(gptp_ts_rv_vaild), .gptp_ts_rv_data(gptp_ts_rv_data),
        .ts_out_vaild(ts_out_vaild), .ts_out_data(ts_out_data), .ts_out_id(ts_out_id),
        .ts_out_err(ts_out_err), .busy(busy)
    );

    always #5 clk_sd = ~clk_sd;

    // Per-cycle stimulus of the current phase.
    logic [N-1:0]  a_req [MAXL];
    logic [N-1:0]  a_en  [MAXL];
    logic          a_rdy [MAXL];
    logic          a_rv  [MAXL];
    logic [TW-1:0] a_rvd [MAXL];
    logic [FW-1:0] a_dat [MAXL][N];

    // Expected outputs per cycle.
    logic          e_vld [MAXL];
    logic [N-1:0]  e_rr  [MAXL];
    logic          e_tv  [MAXL];
    logic          e_err [MAXL];
    logic          e_busy[MAXL];
    logic [FW-1:0] e_dat [MAXL];
    logic [TW-1:0] e_ts  [MAXL];
    logic [2:0]    e_id  [MAXL];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit active = 1'b0;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Schedule model: each transaction is a grant cycle g, a send window ending at the
    // first ready cycle s, a timestamp window of T cycles, then MG gap cycles.
    task automatic build_model(input int L);
        int c, g, s, w, win, rr, fin;
        logic [N-1:0] cand;
        for (int k = 0; k <= L; k++) begin
            e_vld[k] = 0; e_rr[k] = '0; e_tv[k] = 0; e_err[k] = 0; e_busy[k] = 0;
            e_dat[k] = '0; e_ts[k] = '0; e_id[k] = '0;
        end
        rr = 0;
        c  = 0;
        while (c < L) begin
            g = -1;
            for (int k = c; k < L && g < 0; k++) if ((a_req[k] & a_en[k]) != 0) g = k;
            if (g < 0) break;
            cand = a_req[g] & a_en[g];
            win  = -1;
            for (int k = 0; k < N; k++) if (win < 0 && cand[(rr + k) % N]) win = (rr + k) % N;
            rr = (win + 1) % N;
            e_rr[g+1] = N'(1) << win;
            for (int k = g + 1; k <= L; k++) begin
                e_dat[k] = a_dat[g][win];
                e_id[k]  = 3'(win);
            end
            s = -1;
            for (int k = g + 1; k < L && s < 0; k++) if (a_rdy[k]) s = k;
            fin = (s < 0) ? L : s;
            for (int k = g + 1; k <= fin; k++) e_vld[k] = 1;
            if (s < 0) begin
                for (int k = g + 1; k <= L; k++) e_busy[k] = 1;
                break;
            end
            w = -1;
            for (int k = s + 1; k <= s + T && k < L && w < 0; k++) if (a_rv[k]) w = k;
            if (w >= 0) begin
                fin = w + 1;
                e_tv[fin] = 1;
                for (int k = fin; k <= L; k++) e_ts[k] = a_rvd[w];
            end else if (s + T < L) begin
                fin = s + T + 1;
                e_err[fin] = 1;
            end else begin
                for (int k = g + 1; k <= L; k++) e_busy[k] = 1;
                break;
            end
            for (int k = g + 1; k <= fin + MG - 1 && k <= L; k++) e_busy[k] = 1;
            c = fin + MG;
        end
    endtask

    task automatic gen(input int kind, input int L);
        int hold;
        logic [N-1:0] en;
        hold = 0;
        en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
        for (int c = 0; c < MAXL; c++) begin
            a_req[c] = '0; a_en[c] = '1; a_rdy[c] = 1; a_rv[c] = 0;
            a_rvd[c] = {$urandom, $urandom, $urandom};
            for (int i = 0; i < N; i++)
                for (int j = 0; j < FW / 32; j++) a_dat[c][i][j*32 +: 32] = $urandom;
        end
        case (kind)
            0: begin
                a_req[2] = 4'b0100;
                a_rv[6]  = 1;
                a_rvd[6] = 80'h0001_00000005_0000000A;
            end
            1: for (int c = 0; c < L; c++) begin a_req[c] = 4'b1111; a_rv[c] = 1; end
            2: begin
                a_req[0] = 4'b0010; a_req[1] = 4'b0010;
                for (int c = 1; c <= 7; c++) a_rdy[c] = 0;
                a_rv[11] = 1;
            end
            3: begin
                a_req[0] = 4'b1000;
                for (int c = 10; c < L; c++) a_req[c] = 4'b0001;
            end
            4: begin
                a_rv[2] = 1; a_req[5] = 4'b0001;
                a_rv[8] = 1; a_rv[9] = 1;
            end
            5: begin
                for (int c = 0; c < L; c++) begin a_en[c] = 4'b1110; a_req[c] = 4'b0001; end
                a_req[3] = 4'b0101;
            end
            default: for (int c = 0; c < L; c++) begin
                a_en[c]  = en;
                a_req[c] = N'($urandom) & (($urandom_range(0, 1) == 1) ? 4'hF : 4'h0);
                a_rdy[c] = ($urandom_range(0, 9) < 7);
                if (hold > 0) begin
                    a_rv[c] = 1; hold--;
                end else if ($urandom_range(0, 14) == 0) begin
                    a_rv[c] = 1; hold = $urandom_range(0, 2);
                end
            end
        endcase
    endtask

    // Hand-computed expectations; evaluated #1 after the edge that opens cycle c.
    task automatic pins(input int kind, input int c);
        if (c == 0) begin
            chk("rst_vld", gptp_ts_vaild, 0);
            chk("rst_misc", {req_ready, ts_out_vaild, ts_out_err, busy, ts_out_id}, 0);
            chk("rst_data", gptp_ts_data, 0);
            chk("rst_ts", ts_out_data, 0);
        end
        case (kind)
            0: begin
                if (c == 3) begin
                    chk("one_rdy", req_ready, 4'b0100);
                    chk("one_vld", gptp_ts_vaild, 1);
                    chk("one_dat", gptp_ts_data, a_dat[2][2]);
                end
                if (c == 4) chk("one_vld_drop", gptp_ts_vaild, 0);
                if (c == 7) begin
                    chk("one_tv", ts_out_vaild, 1);
                    chk("one_ts", ts_out_data, 80'h0001_00000005_0000000A);
                    chk("one_id", ts_out_id, 3'd2);
                end
            end
            1: if (c >= 1 && c <= 29 && (c - 1) % 7 == 0)
                chk("rr_grant", req_ready, 4'b0001 << (((c - 1) / 7) % 4));
            2: begin
                if (c >= 1 && c <= 8) begin
                    chk("bp_vld", gptp_ts_vaild, 1);
                    chk("bp_dat", gptp_ts_data, a_dat[0][1]);
                end
                if (c == 9) chk("bp_vld_drop", gptp_ts_vaild, 0);
            end
            3: begin
                if (c == 22) begin
                    chk("tmo_err", ts_out_err, 1);
                    chk("tmo_tv", ts_out_vaild, 0);
                end
                if (c == 25) chk("tmo_busy_gap", busy, 1);
                if (c == 26) chk("tmo_busy_idle", busy, 0);
                if (c == 27) chk("tmo_next", req_ready, 4'b0001);
            end
            4: begin
                if (c == 3) chk("stray_tv", {ts_out_vaild, busy}, 0);
                if (c == 9) begin
                    chk("held_tv", ts_out_vaild, 1);
                    chk("held_ts", ts_out_data, a_rvd[8]);
                end
                if (c == 10) chk("held_tv_once", ts_out_vaild, 0);
            end
            5: begin
                chk("mask_r0", req_ready[0], 0);
                if (c == 4) chk("mask_r2", req_ready, 4'b0100);
            end
            default: ;
        endcase
    endtask

    always @(negedge clk_sd) begin
        if (active) begin
            chk("vld",  gptp_ts_vaild, e_vld[cyc]);
            chk("rdy",  req_ready,     e_rr[cyc]);
            chk("tv",   ts_out_vaild,  e_tv[cyc]);
            chk("err",  ts_out_err,    e_err[cyc]);
            chk("busy", busy,          e_busy[cyc]);
            chk("dat",  gptp_ts_data,  e_dat[cyc]);
            chk("ts",   ts_out_data,   e_ts[cyc]);
            chk("id",   ts_out_id,     e_id[cyc]);
        end
    end

    task automatic run_phase(input int kind, input int L);
        gen(kind, L);
        build_model(L);
        reset = 1; req_vaild = '0; gptp_ts_ready = 0; gptp_ts_rv_vaild = 0;
        @(posedge clk_sd); #1;
        for (int c = 0; c <= L; c++) begin
            cyc = c;
            if (c < L) begin
                reset = 0;
                req_en = a_en[c]; req_vaild = a_req[c];
                for (int i = 0; i < N; i++) req_data[i*FW +: FW] = a_dat[c][i];
                gptp_ts_ready = a_rdy[c];
                gptp_ts_rv_vaild = a_rv[c]; gptp_ts_rv_data = a_rvd[c];
            end else begin
                reset = 1; req_vaild = '0; gptp_ts_rv_vaild = 0;
            end
            active = 1;
            pins(kind, c);
            @(posedge clk_sd); #1;
        end
        active = 0;
    endtask

    initial begin
        run_phase(0, 16);
        run_phase(1, 32);
        run_phase(2, 24);
        run_phase(3, 40);
        run_phase(4, 20);
        run_phase(5, 12);
        for (int p = 0; p < 6; p++) run_phase(6, 300);
        run_phase(0, 16);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
